// File: rtl/softlink_master_lite.sv
// softlink_master_lite: AXI4-Lite initiator turning one command into one transaction and one response.
// Optional watchdog enabled by defining SOFTLINK_MASTER_TIMEOUT_EN.
module softlink_master_lite #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 256
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARESETN,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic                              cmd_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_we,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
   output logic [1:0]                        rsp_resp,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
   state_t state_q, state_d;
   logic aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic arvalid_q, arvalid_d, rready_q, rready_d;
   logic rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
   logic [1:0] rsp_resp_q, rsp_resp_d;
   logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
`ifdef SOFTLINK_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] cnt_q, cnt_d;
   logic busy, hs;
`endif
   assign aw_hs = awvalid_q & M_AXI_AWREADY;
   assign w_hs  = wvalid_q & M_AXI_WREADY;
   assign b_hs  = bready_q & M_AXI_BVALID;
   assign ar_hs = arvalid_q & M_AXI_ARREADY;
   assign r_hs  = rready_q & M_AXI_RVALID;
   always_comb begin
      state_d     = state_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_resp_d  = rsp_resp_q;
      rsp_rdata_d = rsp_rdata_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awaddr_d    = awaddr_q;
      araddr_d    = araddr_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            rsp_we_d = cmd_we;
            if (cmd_we) begin
               state_d   = WR_REQ;
               awaddr_d  = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end else begin
               state_d   = RD_REQ;
               araddr_d  = cmd_addr;
               arvalid_d = 1'b1;
            end
         end
         // AW and W complete independently; B is only accepted once both are done
         WR_REQ: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            awvalid_d = awvalid_q & ~aw_hs;
            wvalid_d  = wvalid_q & ~w_hs;
            if (aw_done_d && w_done_d) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: if (b_hs) begin
            bready_d    = 1'b0;
            rsp_resp_d  = M_AXI_BRESP;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
         end
         RD_REQ: if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RD_DATA;
         end
         RD_DATA: if (r_hs) begin
            rready_d    = 1'b0;
            rsp_resp_d  = M_AXI_RRESP;
            rsp_rdata_d = M_AXI_RDATA;
            rsp_valid_d = 1'b1;
            state_d     = RSP;
         end
         RSP: if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
`ifdef SOFTLINK_MASTER_TIMEOUT_EN
      busy = (state_q == WR_REQ) || (state_q == WR_RESP) || (state_q == RD_REQ) || (state_q == RD_DATA);
      hs   = aw_hs | w_hs | b_hs | ar_hs | r_hs;
      // watchdog abandons the bus and reports 2'b11
      if (busy && !hs && cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rsp_resp_d  = 2'b11;
         rsp_rdata_d = '0;
         rsp_valid_d = 1'b1;
         state_d     = RSP;
      end
      cnt_d = (!busy || hs || state_d != state_q) ? '0 : cnt_q + TW'(1);
`endif
   end
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_q     <= IDLE;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_resp_q  <= '0;
         rsp_rdata_q <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awaddr_q    <= '0;
         araddr_q    <= '0;
`ifdef SOFTLINK_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_resp_q  <= rsp_resp_d;
         rsp_rdata_q <= rsp_rdata_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awaddr_q    <= awaddr_d;
         araddr_q    <= araddr_d;
`ifdef SOFTLINK_MASTER_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end
   assign cmd_ready     = (state_q == IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_we        = rsp_we_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_softlink_master_lite.sv
// tb_softlink_master_lite: directed bench with an AXI4-Lite slave and a transaction-level response model.
// Runs the watchdog test when SOFTLINK_MASTER_TIMEOUT_EN is defined.
module tb_softlink_master_lite;
   logic clk = 1'b0;
   logic rst_n;
   logic cmd_valid, cmd_ready, cmd_we;
   logic [3:0] cmd_addr, cmd_wstrb;
   logic [31:0] cmd_wdata;
   logic rsp_valid, rsp_ready, rsp_we;
   logic [31:0] rsp_rdata;
   logic [1:0] rsp_resp;
   logic [3:0] awaddr, araddr, wstrb;
   logic [2:0] awprot, arprot;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [1:0] bresp, rresp;
   int total = 0, bad = 0;
   int aw_lat = 0, w_lat = 0, ar_lat = 0;
   bit b_en = 1;
   logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   logic [31:0] sregs [4];
   logic [31:0] mem [4];
   int c_aw, c_w, c_ar, c_b;
   logic r_we;
   logic [31:0] r_rdata;
   logic [1:0] r_resp;

   softlink_master_lite #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // slave: ready after a programmable number of VALID cycles, response one cycle after the request
   initial begin : slave
      int aw_cnt, w_cnt, ar_cnt;
      bit aw_got, w_got, b_pend, r_pend;
      logic [3:0] wa, ra, ws;
      logic [31:0] wd;
      {awready, wready, bvalid, arready, rvalid} = '0;
      bresp = '0; rresp = '0; rdata = '0;
      {aw_cnt, w_cnt, ar_cnt} = '0;
      {aw_got, w_got, b_pend, r_pend} = '0;
      wa = '0; ra = '0; ws = '0; wd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            {aw_cnt, w_cnt, ar_cnt} = '0;
            {aw_got, w_got, b_pend, r_pend} = '0;
         end else begin
            if (awvalid && awready) begin aw_got = 1; wa = awaddr; aw_cnt = 0; end
            else if (awvalid) aw_cnt++;
            if (wvalid && wready) begin w_got = 1; wd = wdata; ws = wstrb; w_cnt = 0; end
            else if (wvalid) w_cnt++;
            if (aw_got && w_got) begin
               for (int b = 0; b < 4; b++) if (ws[b]) sregs[wa[3:2]][8*b +: 8] = wd[8*b +: 8];
               aw_got = 0; w_got = 0; b_pend = 1;
            end
            if (bvalid && bready) b_pend = 0;
            if (arvalid && arready) begin r_pend = 1; ra = araddr; ar_cnt = 0; end
            else if (arvalid) ar_cnt++;
            if (rvalid && rready) r_pend = 0;
         end
         @(posedge clk); #1;
         awready = awvalid && aw_cnt == aw_lat;
         wready  = wvalid && w_cnt == w_lat;
         arready = arvalid && ar_cnt == ar_lat;
         bvalid  = b_pend && b_en;
         bresp   = bvalid ? b_resp_cfg : 2'b00;
         rvalid  = r_pend;
         rdata   = r_pend ? sregs[ra[3:2]] : 32'h0;
         rresp   = r_pend ? r_resp_cfg : 2'b00;
      end
   end

   // transaction model: expected response and handshake counts per accepted command
   initial begin : model
      bit busy = 0;
      logic e_we;
      logic [3:0] e_addr, e_strb;
      logic [31:0] e_data, e_rdata;
      logic [1:0] e_resp;
      int n_aw, n_w, n_b, n_ar, n_r;
      e_we = 0; e_addr = 0; e_strb = 0; e_data = 0; e_rdata = 0; e_resp = 0;
      {n_aw, n_w, n_b, n_ar, n_r} = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) busy = 0;
         else begin
            chk("cmd_ready", cmd_ready, !busy);
            chk("prot", {awprot, arprot}, 0);
            if (awvalid) begin chk("aw_dir", busy && e_we, 1); chk("awaddr", awaddr, e_addr); end
            if (wvalid) begin chk("w_dir", busy && e_we, 1); chk("wdata", wdata, e_data); chk("wstrb", wstrb, e_strb); end
            if (arvalid) begin chk("ar_dir", busy && !e_we, 1); chk("araddr", araddr, e_addr); end
            if (rsp_valid) begin
               chk("rsp_busy", busy, 1);
               chk("rsp_we", rsp_we, e_we);
               chk("rsp_rdata", rsp_rdata, e_rdata);
               chk("rsp_resp", rsp_resp, e_resp);
            end
            n_aw += int'(awvalid && awready);
            n_w  += int'(wvalid && wready);
            n_b  += int'(bvalid && bready);
            n_ar += int'(arvalid && arready);
            n_r  += int'(rvalid && rready);
            if (rsp_valid && rsp_ready) begin
               chk("n_aw", n_aw, e_we);
               chk("n_w", n_w, e_we);
               chk("n_b", n_b, e_we && b_en);
               chk("n_ar", n_ar, !e_we);
               chk("n_r", n_r, !e_we);
               busy = 0;
            end
            if (cmd_valid && cmd_ready) begin
               busy = 1;
               e_we = cmd_we; e_addr = cmd_addr; e_data = cmd_wdata; e_strb = cmd_wstrb;
               {n_aw, n_w, n_b, n_ar, n_r} = '0;
               if (cmd_we) begin
                  for (int b = 0; b < 4; b++) if (cmd_wstrb[b]) mem[cmd_addr[3:2]][8*b +: 8] = cmd_wdata[8*b +: 8];
                  e_rdata = 0;
                  e_resp = b_en ? b_resp_cfg : 2'b11;
               end else begin
                  e_rdata = mem[cmd_addr[3:2]];
                  e_resp = r_resp_cfg;
               end
            end
         end
      end
   end

   task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      @(negedge clk);
      for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
      chk("cmd_accept", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
   endtask

   task automatic wait_rsp();
      bit done = 0;
      c_aw = 0; c_w = 0; c_ar = 0; c_b = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         c_aw += int'(awvalid); c_w += int'(wvalid); c_ar += int'(arvalid); c_b += int'(bready);
         if (rsp_valid && rsp_ready) begin
            r_we = rsp_we; r_rdata = rsp_rdata; r_resp = rsp_resp; done = 1;
            break;
         end
      end
      chk("rsp_seen", done, 1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      rst_n = 0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
      r_we = 0; r_rdata = 0; r_resp = 0;
      for (int i = 0; i < 4; i++) begin sregs[i] = 0; mem[i] = 0; end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_addr_strb_resp", {awaddr, araddr, wstrb, rsp_resp}, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_rdata", rsp_rdata, 0);
      @(posedge clk); #1;
      rst_n = 1; rsp_ready = 1;
      // zero-wait write: AW/W at N+1, B at N+2, response at N+3, ready again at N+4
      send(1, 4'h0, 32'h40800000, 4'hF);
      @(negedge clk); chk("t1_aw_w_valid", {awvalid, wvalid}, 2'b11);
      @(posedge clk); @(negedge clk); chk("t1_bready", bready, 1);
      @(posedge clk); @(negedge clk); chk("t1_rsp", {rsp_valid, rsp_resp}, 3'b100);
      @(posedge clk); @(negedge clk); chk("t1_next_ready", cmd_ready, 1);
      chk("t1_slave_reg0", sregs[0], 32'h40800000);
      @(posedge clk); #1;
      send(0, 4'h0, 32'h0, 4'h0); wait_rsp();
      chk("t1_readback", r_rdata, 32'h40800000);
      // AW before W, then W before AW
      w_lat = 3;
      send(1, 4'h0, 32'h40808000, 4'hF); wait_rsp();
      chk("t2a_aw_cycles", c_aw, 1); chk("t2a_w_cycles", c_w, 4); chk("t2a_b_cycles", c_b, 1);
      w_lat = 0; aw_lat = 3;
      send(1, 4'hC, 32'h40808000, 4'hF); wait_rsp();
      chk("t2b_aw_cycles", c_aw, 4); chk("t2b_w_cycles", c_w, 1); chk("t2b_b_cycles", c_b, 1);
      aw_lat = 0;
      // read with two ARREADY wait cycles
      sregs[1] = 32'h12345678; mem[1] = 32'h12345678; ar_lat = 2;
      send(0, 4'h4, 32'h0, 4'h0); wait_rsp();
      chk("t3_ar_cycles", c_ar, 3); chk("t3_rdata", r_rdata, 32'h12345678);
      chk("t3_resp", r_resp, 0); chk("t3_we", r_we, 0);
      ar_lat = 0;
      // SLVERR pass-through and a single-byte strobe
      b_resp_cfg = 2'b10; r_resp_cfg = 2'b10;
      send(1, 4'h0, 32'h000000FF, 4'b0001); wait_rsp();
      chk("t_slverr_b", r_resp, 2'b10);
      send(0, 4'h0, 32'h0, 4'h0); wait_rsp();
      chk("t_slverr_r", r_resp, 2'b10); chk("t_strb_rdata", r_rdata, 32'h408080FF);
      b_resp_cfg = 0; r_resp_cfg = 0;
      // response back-pressure; a queued command waits for the handshake
      rsp_ready = 0;
      send(1, 4'h8, 32'hA5A50001, 4'b0011);
      for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_cmd_ready", cmd_ready, 0); chk("t4_hold_rsp_valid", rsp_valid, 1);
         @(posedge clk); #1;
         if (i == 0) begin cmd_valid = 1; cmd_we = 0; cmd_addr = 4'h8; cmd_wdata = 0; cmd_wstrb = 0; end
         if (i == 4) rsp_ready = 1;
         @(negedge clk);
      end
      chk("t4_hs_cmd_ready", cmd_ready, 0); chk("t4_hs_rsp_valid", rsp_valid, 1);
      @(posedge clk); @(negedge clk);
      chk("t4_after_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
      wait_rsp();
      chk("t4_rdata", r_rdata, 32'h00000001);
      // reset while waiting for B
      b_en = 0;
      send(1, 4'hC, 32'hDEADBEEF, 4'hF);
      @(negedge clk); chk("t5_awvalid", awvalid, 1);
      @(posedge clk); @(negedge clk); chk("t5_bready", bready, 1);
      #2 rst_n = 0;
      #1;
      chk("t5_rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
      chk("t5_rst_wdata", wdata, 0); chk("t5_rst_awaddr", awaddr, 0); chk("t5_rst_cmd_ready", cmd_ready, 1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1; b_en = 1;
      repeat (3) begin
         @(negedge clk); chk("t5_no_rsp", rsp_valid, 0); chk("t5_cmd_ready", cmd_ready, 1);
      end
      @(posedge clk); #1;
`ifdef SOFTLINK_MASTER_TIMEOUT_EN
      // watchdog: slave never answers B
      b_en = 0;
      send(1, 4'h4, 32'h00000011, 4'hF); wait_rsp();
      chk("t6_bready_cycles", c_b, 16); chk("t6_resp", r_resp, 2'b11);
      chk("t6_rdata", r_rdata, 0); chk("t6_we", r_we, 1);
      pulse_reset();
      b_en = 1;
`endif
      send(0, 4'h8, 32'h0, 4'h0); wait_rsp();
      chk("final_read", r_rdata, 32'h00000001);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/softlink_master_lite.md
Name: softlink_master_lite

Overview:
- AXI4-Lite initiator (master) that drives the softlink slave register file of the softmax accelerator from an internal command/response stream.
- Converts one command (write or read) into one AXI4-Lite transaction and returns one response.
- Sits between the host-side sequencer, or on-chip test driver, and the softlink_slave_lite slave port.
- One outstanding transaction at a time. AW and W are issued concurrently.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI address width; must match the slave.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with SOFTLINK_MASTER_TIMEOUT_EN; must be at least 2.

Ports:
- M_AXI_ACLK  in  1  single clock; all logic rising-edge.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data (ignored for reads).
- cmd_wstrb  in  4  byte strobes (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_we  out  1  echo of the command type.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP value (or timeout code, see Optional Feature).
- M_AXI_AWADDR  out  ADDR_WIDTH
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_AWVALID  out  1
- M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32
- M_AXI_WSTRB  out  4
- M_AXI_WVALID  out  1
- M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2
- M_AXI_BVALID  in  1
- M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_WIDTH
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_ARVALID  out  1
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; cmd_ready=1; all VALID/READY outputs=0; rsp_valid=0; all address/data/resp outputs=0.
- Asserting reset mid-transaction aborts immediately with no response. The slave must be reset in the same domain.
- All AXI outputs are registered. No combinational path from any AXI input to any AXI output.
- State IDLE: cmd_ready=1. On cmd_valid, capture addr/data/strb/we.
  - Write: go to WR_REQ; AWVALID=WVALID=1 from the next cycle.
  - Read: go to RD_REQ; ARVALID=1 from the next cycle.
- State WR_REQ: separate aw_done and w_done flags.
  - AWVALID drops the cycle after the AW handshake; WVALID drops the cycle after the W handshake, independently.
  - Address and data stay stable while their VALID is high.
  - When both flags are set (same or different cycles), go to WR_RESP with BREADY=1.
- State WR_RESP: on BVALID, capture BRESP, BREADY=0, rsp_valid=1, go to RSP.
- State RD_REQ: ARVALID is held until ARREADY. Then ARVALID=0, RREADY=1, go to RD_DATA.
- State RD_DATA: on RVALID, capture RDATA/RRESP, RREADY=0, rsp_valid=1, go to RSP.
- State RSP: rsp_* held stable until rsp_ready. cmd_ready=0 in every state except IDLE. On the rsp handshake, go to IDLE.
- Best-case latency, with a zero-wait slave and rsp_ready=1:
  - Write: cmd accepted at cycle N; AW/W at N+1; B at N+2; rsp_valid at N+3; next cmd accepted at N+4.
  - Read: same timing with AR/R in place of AW/W and B.
- BVALID or RVALID arriving outside WR_RESP/RD_DATA is ignored; READY stays 0.
- BRESP/RRESP are passed through unmodified (OKAY=00, SLVERR=10).

Optional Feature:
- Macro SOFTLINK_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA. It resets on every state entry and on any channel handshake.
  - On reaching TIMEOUT_CYCLES, all VALID/READY outputs drop, rsp_resp=2'b11, rsp_rdata=0, and the block goes to RSP.
  - This is a debug aid that deliberately breaks the AXI handshake; the slave must be reset afterwards.
- Undefined: no counter. The block waits indefinitely.

Test Plan:
- Zero-wait slave, write addr 0x0, data 0x40800000, strb 0xF. Required: AWVALID and WVALID both high at N+1; BREADY high at N+2; rsp_valid at N+3 with rsp_resp=00; slave reg0 reads back 0x40800000.
- Slave raises AWREADY 3 cycles before WREADY, then the reverse order, data 0x40808000. Required: exactly one AW and one W handshake; each VALID drops alone; one BREADY pulse; one response.
- Read addr 0x4 returning 0x12345678 with 2 ARREADY wait cycles. Required: ARVALID held 3 cycles; rsp_rdata=0x12345678, rsp_resp=00, rsp_we=0.
- rsp_ready held low 5 cycles after rsp_valid. Required: rsp_* stable; cmd_ready=0 throughout; the next command is accepted only in the cycle after the handshake.
- Assert M_AXI_ARESETN low while in WR_RESP. Required: all outputs 0 in the same cycle; cmd_ready=1 after release; no rsp_valid.
- With SOFTLINK_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts BVALID. Required: BREADY drops after 16 cycles in WR_RESP; rsp_resp=11, rsp_rdata=0.
